// File: rtl/pow_spec_stream.sv
// pow_spec_stream
// Streaming power-spectrum stage between an FFT core and the mel filterbank.
// Each accepted bin produces (re^2 + im^2) >> SHIFT, optionally clamped, tagged
// with its bin index and an end-of-frame flag. A single global advance enable
// moves every stage together, so backpressure never reorders or drops bins.
// Frame-length violations raise a one-cycle frame_err and the bin counter
// resynchronises on its own; the upstream FFT never has to be reset.
module pow_spec_stream #(
  parameter int N          = 512,
  parameter int IN_W       = 32,
  parameter int OUT_W      = 32,
  parameter int SHIFT      = $clog2(N),
  parameter int MUL_STAGES = 3,
  parameter int HALF_ONLY  = 1,
  parameter int SATURATE   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic signed [IN_W-1:0] s_re,
  input  logic signed [IN_W-1:0] s_im,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   s_last,
  output logic [OUT_W-1:0]       m_data,
  output logic [$clog2(N)-1:0]   m_bin,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic                   frame_err
);

  localparam int BW = $clog2(N);
  // Squares are kept at full product width; the sum needs one extra bit.
  localparam int PW = 2 * IN_W;
  localparam int SW = PW + 1;
  // Working width for the shifted sum: always at least one bit wider than the
  // output so the saturation test has a non-empty upper field to look at.
  localparam int EW = (SW > OUT_W) ? SW : OUT_W + 1;
  localparam int LS = MUL_STAGES - 1;

  localparam logic [BW-1:0] MAX_IDX  = BW'(N - 1);
  localparam logic [BW-1:0] HALF_IDX = BW'(N / 2);
  localparam logic [BW-1:0] LAST_IDX = (HALF_ONLY != 0) ? HALF_IDX : MAX_IDX;

  // Clamp (or truncate) the shifted sum of squares to the output width.
  function automatic logic [OUT_W-1:0] clamp_pow(input logic [EW-1:0] p);
    if ((SATURATE != 0) && (|p[EW-1:OUT_W])) begin
      return {OUT_W{1'b1}};
    end else begin
      return p[OUT_W-1:0];
    end
  endfunction

  // Handshake / frame bookkeeping
  logic          en_s;
  logic          in_xfer_s;
  logic          at_max_s;
  logic          fwd_s;
  logic [BW-1:0] cnt_q;
  logic [BW-1:0] cnt_d;
  logic          err_d;
  logic          frame_err_q;

  // Input register stage
  logic                   v0_q;
  logic signed [IN_W-1:0] re0_q;
  logic signed [IN_W-1:0] im0_q;
  logic [BW-1:0]          bin0_q;
  logic                   last0_q;

  // Squarer stages
  logic signed [PW-1:0] re_ext_s;
  logic signed [PW-1:0] im_ext_s;
  logic signed [PW-1:0] sq_re_s;
  logic signed [PW-1:0] sq_im_s;
  logic [PW-1:0]        sq_re_q [MUL_STAGES];
  logic [PW-1:0]        sq_im_q [MUL_STAGES];
  logic                 vm_q    [MUL_STAGES];
  logic [BW-1:0]        binm_q  [MUL_STAGES];
  logic                 lastm_q [MUL_STAGES];

  // Add / shift / clamp and output register
  logic [SW-1:0]    sum_s;
  logic [EW-1:0]    p_s;
  logic [OUT_W-1:0] data_s;
  logic             m_valid_q;
  logic [OUT_W-1:0] m_data_q;
  logic [BW-1:0]    m_bin_q;
  logic             m_last_q;

  // The whole pipeline advances unless the output holds data nobody takes.
  assign en_s      = !m_valid_q | m_ready;
  assign s_ready   = en_s & !reset;
  assign in_xfer_s = s_valid & s_ready;
  assign at_max_s  = (cnt_q == MAX_IDX);
  // Upper half of the spectrum is accepted but dropped when HALF_ONLY is set.
  assign fwd_s     = (HALF_ONLY == 0) || (cnt_q <= HALF_IDX);

  // Next bin index and frame-length check; s_last must coincide with bin N-1.
  always_comb begin
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (in_xfer_s) begin
      if (s_last || at_max_s) begin
        cnt_d = {BW{1'b0}};
      end else begin
        cnt_d = cnt_q + BW'(1);
      end
      err_d = s_last ^ at_max_s;
    end else begin
      cnt_d = cnt_q;
      err_d = 1'b0;
    end
  end

  // Bin counter and one-cycle frame error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= {BW{1'b0}};
      frame_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      frame_err_q <= err_d;
    end
  end

  // Input register: capture the accepted bin together with its tags.
  always_ff @(posedge clk) begin
    if (reset) begin
      v0_q    <= 1'b0;
      re0_q   <= {IN_W{1'b0}};
      im0_q   <= {IN_W{1'b0}};
      bin0_q  <= {BW{1'b0}};
      last0_q <= 1'b0;
    end else if (en_s) begin
      v0_q    <= in_xfer_s & fwd_s;
      re0_q   <= s_re;
      im0_q   <= s_im;
      bin0_q  <= cnt_q;
      last0_q <= (cnt_q == LAST_IDX);
    end
  end

  // Sign-extend before multiplying so the most negative input squares exactly.
  assign re_ext_s = PW'(re0_q);
  assign im_ext_s = PW'(im0_q);
  assign sq_re_s  = re_ext_s * re_ext_s;
  assign sq_im_s  = im_ext_s * im_ext_s;

  // Squarer pipeline; trailing stages give the multiplier room to be retimed.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < MUL_STAGES; k++) begin
        sq_re_q[k] <= {PW{1'b0}};
        sq_im_q[k] <= {PW{1'b0}};
        vm_q[k]    <= 1'b0;
        binm_q[k]  <= {BW{1'b0}};
        lastm_q[k] <= 1'b0;
      end
    end else if (en_s) begin
      sq_re_q[0] <= sq_re_s;
      sq_im_q[0] <= sq_im_s;
      vm_q[0]    <= v0_q;
      binm_q[0]  <= bin0_q;
      lastm_q[0] <= last0_q;
      for (int k = 1; k < MUL_STAGES; k++) begin
        sq_re_q[k] <= sq_re_q[k-1];
        sq_im_q[k] <= sq_im_q[k-1];
        vm_q[k]    <= vm_q[k-1];
        binm_q[k]  <= binm_q[k-1];
        lastm_q[k] <= lastm_q[k-1];
      end
    end
  end

  // Squares are non-negative, so they add as unsigned with one carry bit.
  assign sum_s  = {1'b0, sq_re_q[LS]} + {1'b0, sq_im_q[LS]};
  assign p_s    = EW'(sum_s) >> SHIFT;
  assign data_s = clamp_pow(p_s);

  // Output register; payload only changes when a valid bin moves in.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid_q <= 1'b0;
      m_data_q  <= {OUT_W{1'b0}};
      m_bin_q   <= {BW{1'b0}};
      m_last_q  <= 1'b0;
    end else if (en_s) begin
      m_valid_q <= vm_q[LS];
      if (vm_q[LS]) begin
        m_data_q <= data_s;
        m_bin_q  <= binm_q[LS];
        m_last_q <= lastm_q[LS];
      end
    end
  end

  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_bin     = m_bin_q;
  assign m_last    = m_last_q;
  assign frame_err = frame_err_q;

endmodule
